// File: rtl/lsu_mem.sv
// Load/store unit memory sequencer: turns one EX-stage load or store into one
// or two word-aligned bus accesses. Misaligned accesses are either split in two
// or trapped, bus accesses are bounded by a timeout, and loads are byte-assembled
// and extended before being handed back.
module lsu_mem #(
  parameter int ADDR_W         = 32,
  parameter bit SPLIT_MISALIGN = 1'b1,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_zero_ext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              stall,
  output logic              done,
  output logic              load_misalign,
  output logic              store_misalign,
  output logic              access_fault,
  output logic [31:0]       rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_nxt;

  // Lanes touched across the two consecutive words: [3:0] first word, [7:4] second.
  function automatic logic [7:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
    logic [7:0] base;
    case (width)
      2'b00:   base = 8'b0000_0001;
      2'b01:   base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  // Byte rotate left by off bytes so each source byte lands on its bus lane.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      2'd3:    return {d[7:0],  d[31:8]};
      default: return d;
    endcase
  endfunction

  // Zero/sign extension of the low byte/half of an assembled load.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] width,
                                         input logic zext);
    case (width)
      2'b00:   return zext ? {24'd0, d[7:0]}  : {{24{d[7]}},  d[7:0]};
      2'b01:   return zext ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Latched request (data only, qualified by state)
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        width_q;
  logic              zext_q;
  logic [7:0]        lanes_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt;

  logic        req_valid, misalign, accept, split, timeout_hit, final_ack;
  logic [31:0] lo_word, assembled;
  logic [31:0] lane_bits;

  assign req_valid = (req_read ^ req_write) && !flush;
  assign misalign  = ((req_width == 2'b01) && (req_addr[1:0] == 2'd3)) ||
                     ((req_width[1] == 1'b1) && (req_addr[1:0] != 2'd0));
  assign accept    = (state == IDLE) && req_valid && (!misalign || SPLIT_MISALIGN) && !rst;

  assign split       = |lanes_q[7:4];
  assign bus_req     = (state == ACC0) || (state == ACC1);
  assign timeout_hit = bus_req && !bus_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign final_ack   = bus_ack && (((state == ACC0) && !split) || (state == ACC1));

  // Bus side: everything derives from latched state, so it is stable while waiting for ack.
  assign bus_be    = !bus_req ? 4'b0000 : ((state == ACC1) ? lanes_q[7:4] : lanes_q[3:0]);
  assign bus_addr  = (state == ACC1) ? {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00}
                                     : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_we    = bus_req && we_q;
  assign lane_bits = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
  assign bus_wdata = wdata_q & lane_bits;

  // Load assembly: first word is held in lo_q when the access was split.
  assign lo_word   = (state == ACC1) ? lo_q : bus_rdata;
  assign assembled = 32'({bus_rdata, lo_word} >> {addr_q[1:0], 3'b000});

  assign rdata = rdata_q;

  // Next-state and pulse outputs
  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    done           = 1'b0;
    load_misalign  = 1'b0;
    store_misalign = 1'b0;
    access_fault   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ACC0;
          stall     = 1'b1;
        end else if (req_valid && misalign && !SPLIT_MISALIGN && !rst) begin
          load_misalign  = req_read;
          store_misalign = req_write;
        end
      end
      ACC0: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_nxt = split ? ACC1 : RESP;
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          access_fault = !rst;
        end
      end
      ACC1: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          access_fault = !rst;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        done      = !rst;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Per-access cycle counter, restarted on every entry into a bus access
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (((state_nxt == ACC0) || (state_nxt == ACC1)) && (state_nxt != state))
      cnt <= '0;
    else if (bus_req)
      cnt <= cnt + CNT_W'(1);
  end

  // Request capture and first-word buffer
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_write;
      width_q <= req_width;
      zext_q  <= req_zero_ext;
      lanes_q <= lane_mask(req_width, req_addr[1:0]);
      wdata_q <= rotl_bytes(req_wdata, req_addr[1:0]);
    end
    if ((state == ACC0) && bus_ack)
      lo_q <= bus_rdata;
  end

  // Load result, updated on the completing ack so it is valid in RESP
  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (final_ack && !we_q)
      rdata_q <= extend(assembled, width_q, zext_q);
  end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter SPLIT_MISALIGN, default 1: 1 = split misaligned access into two bus accesses; 0 = trap.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles per bus access without bus_ack.
REQ-004 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port flush  in  1: pipeline flush; cancels a request not yet accepted.
REQ-007 SHALL have ports req_read, req_write  in  1 each: load or store request from EX; both high is illegal and is treated as idle.
REQ-008 SHALL have ports req_width  in  2 (00 byte, 01 half, 10 word) and req_zero_ext  in  1.
REQ-009 SHALL have ports req_addr  in  ADDR_W and req_wdata  in  32.
REQ-010 SHALL have ports bus_req, bus_we  out  1; bus_addr  out  ADDR_W (bits [1:0] always 0); bus_be  out  4; bus_wdata  out  32.
REQ-011 SHALL have ports bus_ack  in  1 and bus_rdata  in  32.
REQ-012 SHALL have port stall  out  1: holds IF/ID/EX while an access is in flight.
REQ-013 SHALL have ports done, load_misalign, store_misalign, access_fault  out  1 each, all single-cycle pulses.
REQ-014 SHALL have port rdata  out  32: extended load result.

Function
REQ-015 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-016 IDLE: when (req_read xor req_write) && !flush and the access is aligned or SPLIT_MISALIGN=1, SHALL latch the request and go to ACC0; stall SHALL be 1 in that cycle.
REQ-017 Misalignment SHALL be defined as half at offset 3, or word at offset != 0.
REQ-018 With SPLIT_MISALIGN=0, a misaligned request in IDLE SHALL pulse load_misalign or store_misalign in the same cycle (combinational), start no bus access, and keep stall=0.
REQ-019 bus_req SHALL be 1 exactly in ACC0/ACC1; bus_addr, bus_be, bus_we and bus_wdata SHALL remain stable while bus_req=1 and bus_ack=0.
REQ-020 bus_ack SHALL be sampled only while bus_req=1; an ack in cycle t completes that access at the edge ending t.
REQ-021 ACC0 on ack: SHALL go to ACC1 if the access is split, else to RESP; ACC1 on ack: SHALL go to RESP.
REQ-022 A split access SHALL use ACC0 = word addr A, lanes offset..3, and ACC1 = A+4 (mod 2^ADDR_W), the remaining lanes, with wdata byte-rotated left by offset*8 in both.
REQ-023 Store lanes SHALL be byte 0001<<off and half 0011<<off (truncated to 4 bits, remainder to ACC1).
REQ-024 RESP SHALL assert done=1 and stall=0 for one cycle, then return to IDLE.
REQ-025 For loads, rdata SHALL be valid in RESP and held until the next RESP; the result is the assembled bytes, zero- or sign-extended per width/req_zero_ext; stores SHALL leave rdata unchanged.
REQ-026 A per-access counter SHALL reset on entry to ACC0/ACC1; if TIMEOUT cycles elapse without ack, the block SHALL pulse access_fault, drop bus_req, return to IDLE, and assert no done.
REQ-027 flush in ACC0/ACC1/RESP SHALL be ignored (access is committed); flush in IDLE SHALL suppress acceptance and misalign pulses.
REQ-028 stall SHALL be 1 in ACC0/ACC1 and 0 in RESP.

Reset
REQ-029 rst SHALL force state=IDLE and bus_req=stall=done=all fault pulses=0, rdata=0, counter=0, overriding any in-flight access.
REQ-030 rst asserted mid-access SHALL drop bus_req on the next cycle with no done or fault pulse.

Verification
REQ-031 Aligned lw addr 0x100, ack after 3 cycles, bus_rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, done 1 cycle, rdata 0xDEADBEEF.
REQ-032 lb signed at 0x103 with rdata 0x80112233 -> be 1000, rdata 0xFFFFFF80; with zero_ext -> 0x00000080.
REQ-033 SPLIT=1: sw 0x11223344 at 0x102 -> ACC0 addr 0x100 be 1100 wdata 0x33440000; ACC1 addr 0x104 be 0011 wdata 0x00001122; done once.
REQ-034 SPLIT=0: lh at 0x0FF -> load_misalign pulse in that cycle, bus_req never 1, stall 0.
REQ-035 TIMEOUT=4, no ack -> bus_req 4 cycles, access_fault 1 pulse, IDLE, done never 1.
REQ-036 rst during ACC1 of a split load -> bus_req 0 next cycle, rdata 0, no done.
